// File: rtl/dsp_pipe_stage_if.sv
// -----------------------------------------------------------------------------
// dsp_pipe_stage_if
//
// Handshake bundle for one dsp_pipe_stage instance. Carries the upstream
// valid/ready/data leg, the downstream valid/ready/data leg and the occupancy
// read-back. Clock, reset, clock enable and synchronous clear stay as plain
// module ports on the pipe itself.
//
// Parameters
//   DATA_WIDTH  width of in_data / out_data
//   OCC_WIDTH   width of occ; must equal max(1, $clog2(DEPTH+1)) of the pipe
//
// Modports
//   master  the environment: drives in_valid, in_data, out_ready
//   slave   the pipe stage:  drives in_ready, out_valid, out_data, occ
// -----------------------------------------------------------------------------
interface dsp_pipe_stage_if #(
    parameter int DATA_WIDTH = 18,
    parameter int OCC_WIDTH  = 2
);

    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic [OCC_WIDTH-1:0]  occ;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  occ
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output occ
    );

endinterface : dsp_pipe_stage_if

// File: rtl/dsp_pipe_stage.sv
// -----------------------------------------------------------------------------
// dsp_pipe_stage
//
// Elastic pipeline register for the DSP operand path. DEPTH stages of
// DATA_WIDTH bits, each with its own valid bit, moved forward by a
// valid/ready handshake. Any empty stage always accepts, so bubbles collapse
// while the output is stalled and a pipe of DEPTH stages holds DEPTH items.
// The ready chain is combinational from out_ready back to in_ready, which lets
// a full pipe take a new item in the same cycle it hands one out.
// DEPTH = 0 degenerates to a wire-through with no state.
//
// Optional feature (macro DSP_PIPE_OCC_EN):
//   defined     occ is a registered count of valid stages (0..DEPTH)
//   undefined   no counter is built and occ reads 0
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset: all stages empty, data=RST_VALUE
//   ce         clock enable; low freezes every register and blocks transfers
//   sclr       synchronous clear, honoured even while ce is low
//   bus.in_valid / bus.in_data / bus.in_ready      upstream handshake
//   bus.out_valid / bus.out_data / bus.out_ready   downstream handshake
//   bus.occ    number of valid stages
// -----------------------------------------------------------------------------
module dsp_pipe_stage #(
    parameter int                    DATA_WIDTH = 18,
    parameter int                    DEPTH      = 2,
    parameter logic [DATA_WIDTH-1:0] RST_VALUE  = {DATA_WIDTH{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ce,
    input  logic            sclr,
    dsp_pipe_stage_if.slave bus
);

    localparam int OCC_W = (DEPTH == 0) ? 1 : $clog2(DEPTH + 1);

    // Common qualifier for every transfer. rst_n is folded in so that in_ready
    // and out_valid are held low for the whole reset, not just its edges.
    logic en_s;

    // Transfer enable: clock enabled, no clear this cycle, out of reset.
    always_comb begin
        en_s = ce & ~sclr & rst_n;
    end

    generate
        if (DEPTH == 0) begin : g_bypass

            // Wire-through: both handshake legs gated by the transfer enable.
            always_comb begin
                bus.out_data  = bus.in_data;
                bus.out_valid = bus.in_valid & en_s;
                bus.in_ready  = bus.out_ready & en_s;
                bus.occ       = {OCC_W{1'b0}};
            end

        end else begin : g_pipe

            // Stage 0 is the input side, stage DEPTH-1 drives out_data.
            logic [DATA_WIDTH-1:0] data_r  [DEPTH];
            logic                  v_r     [DEPTH];
            // acc_s[k]: stage k loads at the next edge. acc_s[DEPTH] stands for
            // the downstream consumer.
            logic                  acc_s   [DEPTH+1];
            // What each stage would load: its upstream neighbour's contents.
            logic [DATA_WIDTH-1:0] src_d_s [DEPTH];
            logic                  src_v_s [DEPTH];

            assign src_v_s[0] = bus.in_valid;
            assign src_d_s[0] = bus.in_data;

            for (genvar k = 1; k < DEPTH; k++) begin : g_src
                assign src_v_s[k] = v_r[k-1];
                assign src_d_s[k] = data_r[k-1];
            end

            // Ready chain, output side first: a stage accepts if it is empty
            // or the stage after it is moving on this cycle.
            always_comb begin
                acc_s[DEPTH] = bus.out_ready;
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    acc_s[k] = en_s & (~v_r[k] | acc_s[k+1]);
                end
            end

            // Stage registers: flush on reset or clear, otherwise load the
            // upstream neighbour wherever the ready chain allows. Data only
            // follows a valid item; an emptied stage keeps its stale data.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        v_r[k]    <= 1'b0;
                        data_r[k] <= RST_VALUE;
                    end
                end else if (sclr) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        v_r[k]    <= 1'b0;
                        data_r[k] <= RST_VALUE;
                    end
                end else begin
                    for (int k = 0; k < DEPTH; k++) begin
                        if (acc_s[k]) begin
                            v_r[k] <= src_v_s[k];
                            if (src_v_s[k]) begin
                                data_r[k] <= src_d_s[k];
                            end else begin
                                data_r[k] <= data_r[k];
                            end
                        end else begin
                            v_r[k]    <= v_r[k];
                            data_r[k] <= data_r[k];
                        end
                    end
                end
            end

            // Handshake outputs. out_data comes straight from the last stage
            // register; in_valid reaches no output combinationally.
            always_comb begin
                bus.in_ready  = acc_s[0];
                bus.out_valid = v_r[DEPTH-1] & en_s;
                bus.out_data  = data_r[DEPTH-1];
            end

`ifdef DSP_PIPE_OCC_EN
            logic [OCC_W-1:0] occ_r;
            logic             in_xfer_s;
            logic             out_xfer_s;

            // Transfer strobes for the occupancy counter.
            always_comb begin
                in_xfer_s  = bus.in_valid & acc_s[0];
                out_xfer_s = v_r[DEPTH-1] & en_s & bus.out_ready;
            end

            // Occupancy: up on input-only, down on output-only, else hold.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    occ_r <= {OCC_W{1'b0}};
                end else if (sclr) begin
                    occ_r <= {OCC_W{1'b0}};
                end else if (in_xfer_s & ~out_xfer_s) begin
                    occ_r <= occ_r + OCC_W'(1'b1);
                end else if (out_xfer_s & ~in_xfer_s) begin
                    occ_r <= occ_r - OCC_W'(1'b1);
                end else begin
                    occ_r <= occ_r;
                end
            end

            // Occupancy read-back.
            always_comb begin
                bus.occ = occ_r;
            end
`else
            // No counter built: occupancy reads as zero.
            always_comb begin
                bus.occ = {OCC_W{1'b0}};
            end
`endif

        end
    endgenerate

endmodule : dsp_pipe_stage

// File: tb/tb_dsp_pipe_stage.sv
// -----------------------------------------------------------------------------
// tb_dsp_pipe_stage
//
// Three pipes share one stimulus stream: DEPTH=3 (RST_VALUE=5), DEPTH=2
// (RST_VALUE=0x155) and DEPTH=0. The reference model treats each pipe as a
// FIFO of capacity DEPTH:
//   in_ready  = enabled && (items < DEPTH || out_ready)
//   occ       = items held (0 when the occupancy counter is not built)
//   each item leaves in order, no sooner than DEPTH enabled edges after it
//   entered, and exactly DEPTH if out_ready was high on every enabled edge
//   since it entered.
// A driver process pushes expected items when an input transfer is due; a
// monitor process compares whenever a pipe presents out_valid.
// -----------------------------------------------------------------------------
module tb_dsp_pipe_stage;

    localparam int NCFG   = 3;
    localparam int DW     = 18;
    localparam int N_RAND = 3000;

`ifdef DSP_PIPE_OCC_EN
    localparam bit OCC_ON = 1'b1;
`else
    localparam bit OCC_ON = 1'b0;
`endif

    function automatic int dep(input int g);
        case (g)
            0:       return 3;
            1:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [DW-1:0] rstv(input int g);
        case (g)
            0:       return 18'd5;
            1:       return 18'h00155;
            default: return 18'd0;
        endcase
    endfunction

    typedef struct packed {
        logic [DW-1:0] data;
        logic [31:0]   act;
        logic [31:0]   epoch;
    } item_t;

    logic          clk;
    logic          rst_n;
    logic          ce;
    logic          sclr;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          rdy_a [NCFG];
    logic          ov_a  [NCFG];
    logic [DW-1:0] od_a  [NCFG];
    logic [3:0]    occ_a [NCFG];

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int D  = dep(g);
        localparam int OW = (D == 0) ? 1 : $clog2(D + 1);

        dsp_pipe_stage_if #(.DATA_WIDTH(DW), .OCC_WIDTH(OW)) bus ();

        dsp_pipe_stage #(
            .DATA_WIDTH(DW),
            .DEPTH     (D),
            .RST_VALUE (rstv(g))
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .ce   (ce),
            .sclr (sclr),
            .bus  (bus)
        );

        assign bus.in_valid  = in_valid;
        assign bus.in_data   = in_data;
        assign bus.out_ready = out_ready;
        assign rdy_a[g]      = bus.in_ready;
        assign ov_a[g]       = bus.out_valid;
        assign od_a[g]       = bus.out_data;
        assign occ_a[g]      = 4'(bus.occ);
    end

    // ---------------- model state ----------------
    item_t       sb_q    [NCFG][$];
    bit          exp_rdy [NCFG];
    int          exp_occ [NCFG];
    int          sz_pre  [NCFG];
    bit          en_cur;
    int unsigned act_cnt;
    int unsigned act_edge;
    int unsigned epoch_cnt;

    int n_checks;
    int n_pass;

    task automatic chk(input bit ok, input string what, input int cfg,
                       input longint got, input longint want);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s cfg%0d (depth %0d): got %0d, want %0d",
                      what, cfg, dep(cfg), got, want);
    endtask

    task automatic chk_reset(input string tag);
        for (int i = 0; i < NCFG; i++) begin
            chk(ov_a[i] == 1'b0, {tag, "_out_valid"}, i, ov_a[i], 0);
            chk(rdy_a[i] == 1'b0, {tag, "_in_ready"}, i, rdy_a[i], 0);
            chk(occ_a[i] == 4'd0, {tag, "_occ"}, i, occ_a[i], 0);
            if (dep(i) > 0)
                chk(od_a[i] == rstv(i), {tag, "_out_data"}, i, od_a[i], rstv(i));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver-side model: decides the transfers due at the coming edge and
    // pushes expected items.
    initial begin
        item_t it;
        act_cnt   = 0;
        act_edge  = 0;
        epoch_cnt = 0;
        forever begin
            @(negedge clk);
            en_cur   = ce && !sclr && rst_n;
            act_edge = act_cnt;
            if (en_cur) act_cnt++;
            if (en_cur && !out_ready) epoch_cnt++;
            for (int i = 0; i < NCFG; i++) begin
                if (!rst_n) sb_q[i].delete();
                sz_pre[i]  = sb_q[i].size();
                exp_rdy[i] = en_cur && ((sz_pre[i] < dep(i)) || out_ready);
                exp_occ[i] = OCC_ON ? sz_pre[i] : 0;
                if (in_valid && exp_rdy[i]) begin
                    it.data  = in_data;
                    it.act   = act_edge;
                    it.epoch = epoch_cnt;
                    sb_q[i].push_back(it);
                end
                if (sclr && rst_n) sb_q[i].delete();
            end
        end
    end

    // Monitor: compares handshake outputs and every presented output item.
    initial begin
        item_t head;
        int    lat;
        forever begin
            @(negedge clk);
            #1;
            for (int i = 0; i < NCFG; i++) begin
                chk(rdy_a[i] == exp_rdy[i], "in_ready", i, rdy_a[i], exp_rdy[i]);
                chk(occ_a[i] == 4'(exp_occ[i]), "occ", i, occ_a[i], exp_occ[i]);
                if (dep(i) == 0)
                    chk(ov_a[i] == (in_valid && en_cur), "out_valid", i, ov_a[i],
                        (in_valid && en_cur));
                else
                    chk(!ov_a[i] || (en_cur && sz_pre[i] > 0), "out_valid_legal", i,
                        ov_a[i], 0);
                if (ov_a[i] && sb_q[i].size() > 0) begin
                    head = sb_q[i][0];
                    chk(od_a[i] == head.data, "out_data", i, od_a[i], head.data);
                    if (out_ready) begin
                        void'(sb_q[i].pop_front());
                        lat = int'(act_edge - head.act);
                        chk(lat >= dep(i) && (head.epoch != epoch_cnt || lat == dep(i)),
                            "latency", i, lat, dep(i));
                    end
                end
            end
        end
    end

    // Stimulus.
    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        ce        = 1'b1;
        sclr      = 1'b0;
        in_valid  = 1'b0;
        in_data   = 18'd0;
        out_ready = 1'b0;
        #12;
        chk_reset("reset");
        step();
        rst_n = 1'b1;
        step();

        // Continuous stream with out_ready held high.
        out_ready = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            in_valid = 1'b1;
            in_data  = DW'(k);
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();

        // Stall and collapse: A, bubble, B, then C into a stalled pipe.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 18'h0000A; step();
        in_valid = 1'b0;                     step();
        in_valid = 1'b1; in_data = 18'h0000B; step();
        in_valid = 1'b0;                     repeat (2) step();
        in_valid = 1'b1; in_data = 18'h0000C; step();
        in_data  = 18'h000FF;                repeat (2) step();
        // Full pipe with consumer ready: same-cycle pass-through.
        out_ready = 1'b1;
        in_data = 18'h0000D; step();
        in_data = 18'h0000E; step();
        in_valid = 1'b0;
        repeat (5) step();

        // Freeze with ce low, then clear while still frozen.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 18'h00111; step();
        in_data   = 18'h00222; step();
        ce = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_data   = DW'($urandom);
            out_ready = 1'(($urandom_range(99) < 50));
            step();
        end
        sclr = 1'b1;
        step();
        sclr = 1'b0;
        for (int i = 0; i < NCFG; i++) begin
            if (dep(i) > 0)
                chk(od_a[i] == rstv(i), "sclr_out_data", i, od_a[i], rstv(i));
            chk(occ_a[i] == 4'd0, "sclr_occ", i, occ_a[i], 0);
        end
        ce = 1'b1;
        in_valid = 1'b0;
        step();

        // Randomised traffic with one asynchronous reset mid-stream.
        for (int c = 0; c < N_RAND; c++) begin
            if (c == N_RAND / 2) begin
                @(posedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                chk_reset("reset_mid");
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            in_valid  = 1'(($urandom_range(99) < 70));
            in_data   = DW'($urandom);
            out_ready = 1'(($urandom_range(99) < 60));
            ce        = 1'(($urandom_range(99) < 90));
            sclr      = 1'(($urandom_range(99) < 2));
            step();
        end

        // Drain: everything accepted must come out within a bounded time.
        in_valid  = 1'b0;
        ce        = 1'b1;
        sclr      = 1'b0;
        out_ready = 1'b1;
        repeat (20) step();
        for (int i = 0; i < NCFG; i++)
            chk(sb_q[i].size() == 0, "drain_left", i, sb_q[i].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_dsp_pipe_stage
